// File: rtl/shiftregister_seq.sv
// shiftregister_seq: parametrised sequential shift register with a valid/ready
// command port. Multi-bit shifts run one bit per cycle. A one-cycle done pulse
// marks completion and a serial output carries the last bit shifted out.
module shiftregister_seq #(
    parameter int unsigned DATASIZE   = 8,
    parameter int unsigned AMOUNTSIZE = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [2:0]            mode_i,
    input  logic [AMOUNTSIZE-1:0] amount_i,
    input  logic [DATASIZE-1:0]   load_value_i,
    input  logic                  ser_in_msb_i,
    input  logic                  ser_in_lsb_i,
    output logic [DATASIZE-1:0]   value_o,
    output logic                  ser_out_o,
    output logic                  done_o
);

    localparam logic [2:0] ModeHold  = 3'b000;
    localparam logic [2:0] ModeShl   = 3'b001;
    localparam logic [2:0] ModeShr   = 3'b010;
    localparam logic [2:0] ModeLoad  = 3'b011;
    localparam logic [2:0] ModeRol   = 3'b100;
    localparam logic [2:0] ModeRor   = 3'b101;
    localparam logic [2:0] ModeAsr   = 3'b110;
    localparam logic [2:0] ModeClear = 3'b111;

    localparam logic [AMOUNTSIZE-1:0] AmountOne = AMOUNTSIZE'(1);

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [DATASIZE-1:0]   r_value;
    logic [DATASIZE-1:0]   w_value_next;
    logic                  r_ser_out;
    logic                  w_ser_out_next;
    logic                  r_done;
    logic                  w_done_next;
    logic [AMOUNTSIZE-1:0] r_count;
    logic [AMOUNTSIZE-1:0] w_count_next;
    logic [2:0]            r_mode;
    logic [2:0]            w_mode_next;

    logic                  w_idle;
    logic                  w_accept;
    logic                  w_is_shift;
    logic [2:0]            w_step_mode;
    logic [DATASIZE-1:0]   w_step_value;
    logic                  w_step_out;

    assign w_idle   = (r_state == StIdle);
    assign w_accept = cmd_valid_i && w_idle;

    // In IDLE the step uses the incoming mode; in SHIFT it uses the latched one.
    assign w_step_mode = w_idle ? mode_i : r_mode;

    // Classify the incoming mode as a stepping (shift/rotate) operation.
    always_comb begin
        w_is_shift = 1'b0;
        unique case (mode_i)
            ModeShl, ModeShr, ModeRol, ModeRor, ModeAsr: w_is_shift = 1'b1;
            default:                                     w_is_shift = 1'b0;
        endcase
    end

    // One-bit step of the current register value and the bit it pushes out.
    always_comb begin
        w_step_value = r_value;
        w_step_out   = r_ser_out;
        unique case (w_step_mode)
            ModeShl: begin
                w_step_value = {r_value[DATASIZE-2:0], ser_in_lsb_i};
                w_step_out   = r_value[DATASIZE-1];
            end
            ModeShr: begin
                w_step_value = {ser_in_msb_i, r_value[DATASIZE-1:1]};
                w_step_out   = r_value[0];
            end
            ModeRol: begin
                w_step_value = {r_value[DATASIZE-2:0], r_value[DATASIZE-1]};
                w_step_out   = r_value[DATASIZE-1];
            end
            ModeRor: begin
                w_step_value = {r_value[0], r_value[DATASIZE-1:1]};
                w_step_out   = r_value[0];
            end
            ModeAsr: begin
                w_step_value = {r_value[DATASIZE-1], r_value[DATASIZE-1:1]};
                w_step_out   = r_value[0];
            end
            default: begin
                w_step_value = r_value;
                w_step_out   = r_ser_out;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: only shifts of two or more steps leave IDLE.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept && w_is_shift && (amount_i > AmountOne)) begin
                    w_state_next = StShift;
                end
            end
            StShift: begin
                if (r_count == AmountOne) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Output decode: ready is purely a function of state.
    always_comb begin
        cmd_ready_o = 1'b0;
        unique case (r_state)
            StIdle:  cmd_ready_o = 1'b1;
            StShift: cmd_ready_o = 1'b0;
            default: cmd_ready_o = 1'b0;
        endcase
    end

    // Datapath next values. The counter holds the steps still to come after
    // the current edge, so it reaches 1 on the edge before the final step.
    always_comb begin
        w_value_next   = r_value;
        w_ser_out_next = r_ser_out;
        w_count_next   = r_count;
        w_mode_next    = r_mode;
        w_done_next    = 1'b0;
        if (w_idle) begin
            if (w_accept) begin
                w_mode_next = mode_i;
                if (w_is_shift) begin
                    if (amount_i != '0) begin
                        w_value_next   = w_step_value;
                        w_ser_out_next = w_step_out;
                        w_count_next   = amount_i - AmountOne;
                        w_done_next    = (amount_i == AmountOne);
                    end else begin
                        // Zero-step shift: value and serial output both hold.
                        w_done_next = 1'b1;
                    end
                end else begin
                    unique case (mode_i)
                        ModeLoad:  w_value_next = load_value_i;
                        ModeClear: w_value_next = '0;
                        ModeHold:  w_value_next = r_value;
                        default:   w_value_next = r_value;
                    endcase
                    w_done_next = 1'b1;
                end
            end
        end else begin
            w_value_next   = w_step_value;
            w_ser_out_next = w_step_out;
            w_count_next   = r_count - AmountOne;
            w_done_next    = (r_count == AmountOne);
        end
    end

    // Datapath registers; reset aborts any command in flight without a done.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_value   <= '0;
            r_ser_out <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= '0;
            r_mode    <= ModeHold;
        end else begin
            r_value   <= w_value_next;
            r_ser_out <= w_ser_out_next;
            r_done    <= w_done_next;
            r_count   <= w_count_next;
            r_mode    <= w_mode_next;
        end
    end

    assign value_o   = r_value;
    assign ser_out_o = r_ser_out;
    assign done_o    = r_done;

`ifndef SYNTHESIS
    // Completion always lands back in IDLE, ready for the next command.
    a_done_ready : assert property (@(posedge clk_i) disable iff (rst_i)
        done_o |-> cmd_ready_o);
    // The step counter is only live while shifting.
    a_idle_count : assert property (@(posedge clk_i) disable iff (rst_i)
        (r_state == StIdle) |-> (r_count == '0));
    // A shift in progress always has at least one step left.
    a_shift_count : assert property (@(posedge clk_i) disable iff (rst_i)
        (r_state == StShift) |-> (r_count != '0));
`endif

endmodule

// File: doc/shiftregister_seq.md
# shiftregister_seq

Parametrised sequential shift register, successor to the 4-mode shift register. It adds rotate, arithmetic-shift and clear modes, multi-bit shifts executed one bit per cycle, a valid/ready command handshake, a completion pulse and a serial output. It sits as a datapath peripheral driven by a control FSM and is verified formally with assertion modules bound to its ports.

## Interface
- DATASIZE, 8, register width; legal values are 2 and above.
- AMOUNTSIZE, 4, width of the shift-amount field; amounts range from 0 to 2^AMOUNTSIZE-1.

Ports:
- clk_i  in  1  clock. All logic is rising-edge.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  block can accept a command.
- mode_i  in  3  operation. Latched on acceptance.
- amount_i  in  AMOUNTSIZE  shift step count. Latched on acceptance.
- load_value_i  in  DATASIZE  parallel load data. Sampled on acceptance.
- ser_in_msb_i  in  1  fill bit for logical shift right. Sampled on every step.
- ser_in_lsb_i  in  1  fill bit for shift left. Sampled on every step.
- value_o  out  DATASIZE  register contents.
- ser_out_o  out  1  bit shifted or rotated out by the last step.
- done_o  out  1  one-cycle pulse when a command completes.

## Operation
- Modes:
  - 000 hold
  - 001 shift left, fill ser_in_lsb_i
  - 010 shift right, fill ser_in_msb_i
  - 011 load load_value_i
  - 100 rotate left
  - 101 rotate right
  - 110 arithmetic shift right, fill with the current MSB
  - 111 clear to 0
- FSM states: IDLE and SHIFT. cmd_ready_o is 1 exactly in IDLE.
- A command is accepted at a rising edge where cmd_valid_i and cmd_ready_o are both 1. When cmd_ready_o is 0, cmd_valid_i is ignored and not queued.
- Single-cycle commands (hold, load, clear, or any shift mode with amount 0):
  - The result is applied at the acceptance edge.
  - The FSM stays in IDLE.
  - done_o is 1 in the following cycle.
- Shift modes with amount N ≥ 1:
  - The first step is applied at the acceptance edge; remaining steps are applied on the next N-1 edges.
  - Internal counter is loaded with N-1. The FSM enters SHIFT if N > 1 and returns to IDLE after the final step.
  - mode_i, amount_i and load_value_i changes during SHIFT have no effect.
- Rotates with N ≥ DATASIZE wrap naturally. For example, rotate by DATASIZE+1 equals rotate by 1 but takes DATASIZE+1 cycles.
- ser_out_o:
  - Left modes (001, 100): takes the old MSB.
  - Right modes (010, 101, 110): takes the old LSB.
  - Updated only on shift steps; it holds on hold, load, clear and in IDLE.
- value_o holds in IDLE when no command is accepted.
- Reset values: value_o 0, ser_out_o 0, done_o 0, cmd_ready_o 1, state IDLE, counter 0.
- Reset during SHIFT aborts the command: outputs take their reset values next cycle and no done_o is issued. Reset has priority over acceptance.

## Timing
- Latency from acceptance to done_o is max(N,1) cycles.
- done_o is high in the cycle where value_o first shows the final result.
- cmd_ready_o is 1 in the done_o cycle, so back-to-back commands are possible with no idle gap.
- cmd_ready_o is 0 for N-1 cycles after acceptance of an N-step shift.
- Each intermediate step is visible on value_o one cycle after its edge.
- Serial fill inputs are sampled at the edge where their step is applied.
- All outputs are registered; there is no combinational input-to-output path except cmd_ready_o, which is decoded from state.

## Test plan
1. Reset, then load 0xA5 → value_o = 0xA5 next cycle; done_o pulses once; cmd_ready_o stays 1.
2. From 0xA5, shift left with amount 3 and ser_in_lsb_i = 1 → value_o steps through 0x4B, 0x97, 0x2F; ser_out_o steps through 1, 0, 1; cmd_ready_o is 0 for 2 cycles; done_o is 1 with 0x2F.
3. Load 0x90, then arithmetic shift right with amount 2 → value_o = 0xE4. Load 0x01, then rotate right with amount 9 → value_o = 0x80 after 9 cycles.
4. Shift left with amount 0 on 0x3C → value_o stays 0x3C and done_o is 1 after 1 cycle. During a 4-step shift, assert cmd_valid_i with load 0x00 → the load is ignored and the shift result is unaffected.
5. Load 0xFF, then shift right with amount 5 and ser_in_msb_i = 0; assert rst_i at the 2nd step → value_o = 0, cmd_ready_o = 1, no done_o.
6. Hold cmd_valid_i high with load 0x55, then clear on the next cycle → value_o = 0x55 then 0x00; done_o is high on two consecutive cycles.
